// File: rtl/turn_signal_scheduler_pkg.sv
// Shared encodings for the tail-light turn signal scheduler.
// Sweep modes, sweep lengths and the last-phase lookup.
package turn_signal_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_HAZARD = 2'd3
  } mode_e;

  localparam int LEN_IDLE = 1;
  localparam int LEN_TURN = 4;
  localparam int LEN_HAZ  = 2;

  function automatic logic [1:0] last_phase(mode_e m);
    logic [1:0] r;
    case (m)
      MODE_LEFT,
      MODE_RIGHT:  r = 2'(LEN_TURN - 1);
      MODE_HAZARD: r = 2'(LEN_HAZ - 1);
      default:     r = 2'(LEN_IDLE - 1);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a hold-time debouncer.
// A new level is accepted after DEB_CYCLES consecutive differing samples.
module switch_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic Clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic s1;
  logic s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_signal_scheduler.sv
// Debounces turn/hazard switches, arbitrates them and feeds the
// sweep sequencer step enables and requests aligned to sweep ends.
module turn_signal_scheduler
  import turn_signal_scheduler_pkg::*;
#(
  parameter int TICK_DIV   = 12500000,
  parameter int DEB_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       hazard_sw,
  output logic       seq_ce,
  output logic       seq_left,
  output logic       seq_right,
  output logic [1:0] mode,
  output logic       conflict,
  output logic       sweep_done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_PEN  = PW'(TICK_DIV - 2);

  logic lt;
  logic rt;
  logic hz;

  switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_left (
    .Clk   (Clk),
    .reset (reset),
    .raw   (left_sw),
    .level (lt)
  );

  switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_right (
    .Clk   (Clk),
    .reset (reset),
    .raw   (right_sw),
    .level (rt)
  );

  switch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_hazard (
    .Clk   (Clk),
    .reset (reset),
    .raw   (hazard_sw),
    .level (hz)
  );

  logic [PW-1:0] pre;
  logic [1:0]    phase;
  mode_e         cur;
  mode_e         nxt;
  logic          last;

  assign last = (phase == last_phase(cur));
  assign mode = cur;

  always_comb begin
    nxt = MODE_IDLE;
    if (hz)
      nxt = MODE_HAZARD;
    else if (lt && rt)
      nxt = MODE_IDLE;
    else if (lt)
      nxt = MODE_LEFT;
    else if (rt)
      nxt = MODE_RIGHT;
  end

  // Outputs that mark a tick are set one cycle early so they line up with seq_ce.
  always_ff @(posedge Clk) begin
    if (reset) begin
      pre        <= '0;
      seq_ce     <= 1'b0;
      phase      <= '0;
      cur        <= MODE_IDLE;
      seq_left   <= 1'b0;
      seq_right  <= 1'b0;
      conflict   <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      pre        <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      seq_ce     <= (pre == PRE_PEN);
      sweep_done <= (pre == PRE_PEN) && last && (cur != MODE_IDLE);
      conflict   <= lt & rt & ~hz;
      if (seq_ce) begin
        if (last) begin
          phase     <= '0;
          cur       <= nxt;
          seq_left  <= (nxt == MODE_LEFT) || (nxt == MODE_HAZARD);
          seq_right <= (nxt == MODE_RIGHT) || (nxt == MODE_HAZARD);
        end else begin
          phase <= phase + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_turn_signal_scheduler.sv
// Self-checking bench: cycle model of the scheduler rules plus
// directed scenarios and randomized switch activity.
module tb_turn_signal_scheduler;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_sw = 1'b0;
  logic       right_sw = 1'b0;
  logic       hazard_sw = 1'b0;
  logic       seq_ce;
  logic       seq_left;
  logic       seq_right;
  logic [1:0] mode;
  logic       conflict;
  logic       sweep_done;

  turn_signal_scheduler #(.TICK_DIV(TD), .DEB_CYCLES(DB)) u_dut (
    .Clk        (Clk),
    .reset      (reset),
    .left_sw    (left_sw),
    .right_sw   (right_sw),
    .hazard_sw  (hazard_sw),
    .seq_ce     (seq_ce),
    .seq_left   (seq_left),
    .seq_right  (seq_right),
    .mode       (mode),
    .conflict   (conflict),
    .sweep_done (sweep_done)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, holding the values expected after each edge.
  bit m_valid = 0;
  int n;
  int m_mode;
  int m_phase;
  bit m_sl, m_sr, m_ce, m_conf, m_done;
  bit s1[3];
  bit s2[3];
  bit lv[3];
  bit hist[3][DB];

  function automatic int sweep_len(int md);
    if (md == 1 || md == 2) return 4;
    if (md == 3) return 2;
    return 1;
  endfunction

  function automatic int arb(bit l, bit r, bit h);
    if (h) return 3;
    if (l && r) return 0;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  always @(posedge Clk) begin : model
    bit tick;
    bit all_diff;
    bit raw[3];
    raw[0] = left_sw;
    raw[1] = right_sw;
    raw[2] = hazard_sw;
    if (reset) begin
      m_valid = 1;
      n = 0;
      m_mode = 0;
      m_phase = 0;
      {m_sl, m_sr, m_ce, m_conf, m_done} = '0;
      for (int i = 0; i < 3; i++) begin
        s1[i] = 0;
        s2[i] = 0;
        lv[i] = 0;
        for (int k = 0; k < DB; k++) hist[i][k] = 0;
      end
    end else begin
      tick = (n % TD) == TD - 1;
      m_conf = lv[0] & lv[1] & ~lv[2];
      if (tick) begin
        if (m_phase == sweep_len(m_mode) - 1) begin
          m_mode = arb(lv[0], lv[1], lv[2]);
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      m_sl = (m_mode == 1) || (m_mode == 3);
      m_sr = (m_mode == 2) || (m_mode == 3);
      n++;
      m_ce = (n % TD) == TD - 1;
      m_done = m_ce && (m_phase == sweep_len(m_mode) - 1) && (m_mode != 0);
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < DB - 1; k++) hist[i][k] = hist[i][k+1];
        hist[i][DB-1] = s2[i];
        all_diff = 1;
        for (int k = 0; k < DB; k++)
          if (hist[i][k] == lv[i]) all_diff = 0;
        if (all_diff) lv[i] = ~lv[i];
        s2[i] = s1[i];
        s1[i] = raw[i];
      end
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      checks++;
      if ({seq_ce, seq_left, seq_right, mode, conflict, sweep_done} !==
          {m_ce, m_sl, m_sr, 2'(m_mode), m_conf, m_done}) begin
        errors++;
        $display("FAIL model_cmp t=%0t ce/l/r/mode/conf/done got %b exp %b",
                 $time,
                 {seq_ce, seq_left, seq_right, mode, conflict, sweep_done},
                 {m_ce, m_sl, m_sr, 2'(m_mode), m_conf, m_done});
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(negedge Clk);
  endtask

  task automatic wait_mode(input int m, input int lim, input string nm,
                           output int used);
    used = 0;
    while (mode !== 2'(m) && used < lim) begin
      @(negedge Clk);
      used++;
    end
    chk(nm, int'(mode), m);
  endtask

  task automatic wait_ce(input int lim, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge Clk);
      k++;
    end while (seq_ce !== 1'b1 && k < lim);
    chk(nm, int'(seq_ce), 1);
  endtask

  task automatic settle();
    int u;
    left_sw = 0;
    right_sw = 0;
    hazard_sw = 0;
    wait_mode(0, 40, "settle_idle", u);
    cyc(12);
  endtask

  initial begin
    int cnt_ce, cnt_done, bad, u;
    // Reset then idle
    reset = 1;
    cyc(5);
    chk("rst_mode", int'(mode), 0);
    chk("rst_outs", int'({seq_ce, seq_left, seq_right, conflict, sweep_done}), 0);
    reset = 0;
    cnt_ce = 0; cnt_done = 0; bad = 0;
    repeat (16) begin
      @(negedge Clk);
      cnt_ce += int'(seq_ce);
      cnt_done += int'(sweep_done);
      if (mode != 2'd0) bad++;
    end
    chk("idle_ce_count", cnt_ce, 4);
    chk("idle_done_count", cnt_done, 0);
    chk("idle_mode_bad", bad, 0);

    // Left turn, with a pin on the model's debounce latency
    left_sw = 1;
    cyc(4);
    chk("model_deb_4", int'(lv[0]), 0);
    cyc(1);
    chk("model_deb_5", int'(lv[0]), 1);
    wait_mode(1, 20, "left_mode", u);
    chk("left_req", int'({seq_left, seq_right}), 2);
    cnt_ce = 0; cnt_done = 0;
    repeat (32) begin
      @(negedge Clk);
      cnt_ce += int'(seq_ce);
      cnt_done += int'(sweep_done);
    end
    chk("left_ce_count", cnt_ce, 8);
    chk("left_done_count", cnt_done, 2);
    settle();

    // Glitch rejection
    right_sw = 1;
    cyc(2);
    right_sw = 0;
    bad = 0;
    repeat (30) begin
      @(negedge Clk);
      if (mode == 2'd2 || seq_right) bad++;
    end
    chk("glitch_rejected", bad, 0);

    // Hazard pre-emption during LEFT phase 1
    left_sw = 1;
    wait_mode(1, 30, "haz_left_start", u);
    wait_ce(8, "haz_phase0_tick");
    @(negedge Clk);
    hazard_sw = 1;
    bad = 0;
    u = 0;
    while (sweep_done !== 1'b1 && u < 20) begin
      if (mode != 2'd1) bad++;
      @(negedge Clk);
      u++;
    end
    chk("haz_wait_done", int'(sweep_done), 1);
    chk("haz_mode_held", bad, 0);
    chk("haz_left_cycles", u, 11);
    @(negedge Clk);
    chk("haz_mode", int'(mode), 3);
    chk("haz_req", int'({seq_left, seq_right}), 3);
    cnt_done = 0;
    repeat (16) begin
      @(negedge Clk);
      cnt_done += int'(sweep_done);
    end
    chk("haz_done_count", cnt_done, 2);
    settle();

    // Conflict
    left_sw = 1;
    right_sw = 1;
    cyc(8);
    chk("conflict_on", int'(conflict), 1);
    bad = 0;
    repeat (20) begin
      @(negedge Clk);
      if (mode != 2'd0 || !conflict) bad++;
    end
    chk("conflict_idle", bad, 0);
    right_sw = 0;
    wait_mode(1, 20, "conflict_left", u);
    chk("conflict_cleared", int'(conflict), 0);
    settle();

    // Reset mid RIGHT sweep at phase 2
    right_sw = 1;
    wait_mode(2, 30, "rst_right_start", u);
    wait_ce(8, "rst_tick0");
    wait_ce(8, "rst_tick1");
    @(negedge Clk);
    reset = 1;
    @(negedge Clk);
    chk("rst_mid_mode", int'(mode), 0);
    chk("rst_mid_outs", int'({seq_ce, seq_right, sweep_done}), 0);
    reset = 0;
    wait_mode(2, 20, "rst_restart", u);
    chk("rst_restart_cycles", u, 8);
    settle();

    // Randomized switch activity with occasional reset
    repeat (150) begin
      left_sw = 1'($urandom_range(0, 1));
      right_sw = 1'($urandom_range(0, 1));
      hazard_sw = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 39) == 0);
      if (reset) begin
        @(negedge Clk);
        reset = 0;
      end
      cyc($urandom_range(1, 24));
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
